// File: rtl/db9_pkg.sv
// DB9 pad scanner shared definitions.
// Button bit positions, pad line indices, FSM states, shadow bundle.
package db9_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_P6    = 4;
    localparam int JOY_P9    = 5;

    typedef enum logic [1:0] {
        GAP,
        SETTLE,
        PHASE,
        COMMIT
    } db9_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic b;
        logic c;
        logic a;
        logic start;
        logic md;
        logic six;
        logic z;
        logic y;
        logic x;
        logic mode;
    } db9_shadow_t;

    // Buttons a pad type cannot report are forced low here.
    function automatic logic [15:0] db9_pack_word(db9_shadow_t s);
        logic [15:0] w;
        w = '0;
        w[BTN_RIGHT] = s.right;
        w[BTN_LEFT]  = s.left;
        w[BTN_DOWN]  = s.down;
        w[BTN_UP]    = s.up;
        w[BTN_B]     = s.b;
        w[BTN_C]     = s.c;
        if (s.md) begin
            w[BTN_A]     = s.a;
            w[BTN_START] = s.start;
        end
        if (s.md && s.six) begin
            w[BTN_MODE] = s.mode;
            w[BTN_X]    = s.x;
            w[BTN_Y]    = s.y;
            w[BTN_Z]    = s.z;
        end
        return w;
    endfunction

endpackage

// File: rtl/db9_phase_timer.sv
// Loadable down-counter with terminal-count flag.
// clk_i/rst_ni: clock, async active-low reset; load_i/load_val_i:
// reload; tc_o: high while the count is zero.
module db9_phase_timer #(
    parameter int              CNT_W   = 17,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/db9_md_pad_scanner.sv
// Two-port DB9 scanner for Mega Drive 3/6-button and plain pads.
// In: clk_sys, reset_n, joy_in[5:0] (active-low lines).
// Out: joy_split, joy_mdsel, joystick1/2[15:0], md_pad, six_btn,
// frame_done (one-cycle pulse after both words update).
module db9_md_pad_scanner
    import db9_pkg::*;
#(
    parameter int STEP_CYCLES   = 160,
    parameter int SETTLE_CYCLES = 40,
    parameter int GAP_CYCLES    = 80000,
    parameter int CNT_W         = 17
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  joy_in,
    output logic        joy_split,
    output logic        joy_mdsel,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  md_pad,
    output logic [1:0]  six_btn,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STP_LD = CNT_W'(STEP_CYCLES - 1);

    db9_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        split_q, split_d;
    logic        mdsel_q, mdsel_d;
    logic        fdone_q, fdone_d;
    db9_shadow_t sh_q, sh_d;
    logic [15:0] joy1_q, joy1_d;
    logic [15:0] joy2_q, joy2_d;
    logic [1:0]  md_q, md_d;
    logic [1:0]  six_q, six_d;

    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             tc;
    logic [2:0]       idx_inc;
    logic [5:0]       lo;

    assign idx_inc = idx_q + 3'd1;
    // Pad lines are active-low; work with pressed = 1.
    assign lo = ~joy_in;

    db9_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (GAP_LD)
    ) u_timer (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .load_i     (ld),
        .load_val_i (ld_val),
        .tc_o       (tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        split_d = split_q;
        mdsel_d = mdsel_q;
        fdone_d = 1'b0;
        sh_d    = sh_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        md_d    = md_q;
        six_d   = six_q;
        ld      = 1'b0;
        ld_val  = '0;

        unique case (state_q)
            GAP: begin
                split_d = 1'b0;
                mdsel_d = 1'b1;
                if (tc) begin
                    state_d = SETTLE;
                    ld      = 1'b1;
                    ld_val  = SET_LD;
                end
            end

            SETTLE: begin
                mdsel_d = 1'b1;
                if (tc) begin
                    state_d = PHASE;
                    idx_d   = 3'd0;
                    ld      = 1'b1;
                    ld_val  = STP_LD;
                end
            end

            PHASE: begin
                if (tc) begin
                    case (idx_q)
                        3'd0: begin
                            sh_d.up    = lo[JOY_UP];
                            sh_d.down  = lo[JOY_DOWN];
                            sh_d.left  = lo[JOY_LEFT];
                            sh_d.right = lo[JOY_RIGHT];
                            sh_d.b     = lo[JOY_P6];
                            sh_d.c     = lo[JOY_P9];
                        end
                        3'd1: begin
                            // MD pads ground left+right while SELECT is low.
                            sh_d.md    = lo[JOY_LEFT] & lo[JOY_RIGHT];
                            sh_d.a     = lo[JOY_P6];
                            sh_d.start = lo[JOY_P9];
                        end
                        3'd5: begin
                            // Third low pulse: 6-button pads ground all four.
                            sh_d.six = sh_q.md & (lo[3:0] == 4'hF);
                        end
                        3'd6: begin
                            sh_d.z    = lo[JOY_UP];
                            sh_d.y    = lo[JOY_DOWN];
                            sh_d.x    = lo[JOY_LEFT];
                            sh_d.mode = lo[JOY_RIGHT];
                        end
                        default: ;
                    endcase

                    if (idx_q == 3'd7) begin
                        state_d = COMMIT;
                        mdsel_d = 1'b1;
                    end else begin
                        idx_d   = idx_inc;
                        mdsel_d = ~idx_inc[0];
                        ld      = 1'b1;
                        ld_val  = STP_LD;
                    end
                end
            end

            COMMIT: begin
                mdsel_d = 1'b1;
                ld      = 1'b1;
                if (!split_q) begin
                    joy1_d   = db9_pack_word(sh_q);
                    md_d[0]  = sh_q.md;
                    six_d[0] = sh_q.md & sh_q.six;
                    split_d  = 1'b1;
                    state_d  = SETTLE;
                    ld_val   = SET_LD;
                end else begin
                    joy2_d   = db9_pack_word(sh_q);
                    md_d[1]  = sh_q.md;
                    six_d[1] = sh_q.md & sh_q.six;
                    split_d  = 1'b0;
                    fdone_d  = 1'b1;
                    state_d  = GAP;
                    ld_val   = GAP_LD;
                end
            end

            default: begin
                state_d = GAP;
                split_d = 1'b0;
                mdsel_d = 1'b1;
                ld      = 1'b1;
                ld_val  = GAP_LD;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GAP;
            idx_q   <= 3'd0;
            split_q <= 1'b0;
            mdsel_q <= 1'b1;
            fdone_q <= 1'b0;
            sh_q    <= '0;
            joy1_q  <= '0;
            joy2_q  <= '0;
            md_q    <= '0;
            six_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            split_q <= split_d;
            mdsel_q <= mdsel_d;
            fdone_q <= fdone_d;
            sh_q    <= sh_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            md_q    <= md_d;
            six_q   <= six_d;
        end
    end

    assign joy_split  = split_q;
    assign joy_mdsel  = mdsel_q;
    assign joystick1  = joy1_q;
    assign joystick2  = joy2_q;
    assign md_pad     = md_q;
    assign six_btn    = six_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_db9_md_pad_scanner.sv
// Bench for db9_md_pad_scanner with behavioural pad models.
// Vector table plus hand-written reset and mid-frame sequences.
module tb_db9_md_pad_scanner;

    localparam int STEP   = 4;
    localparam int SETTLE = 2;
    localparam int GAPC   = 20;

    localparam int PAD_NONE  = 0;
    localparam int PAD_ATARI = 1;
    localparam int PAD_MD3   = 2;
    localparam int PAD_MD6   = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  joy_in;
    logic        joy_split;
    logic        joy_mdsel;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  md_pad;
    logic [1:0]  six_btn;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          type1 = PAD_NONE;
    int          type2 = PAD_NONE;
    logic [11:0] prs1  = '0;
    logic [11:0] prs2  = '0;

    int   nfall      = 0;
    logic split_prev = 1'b0;
    logic mdsel_prev = 1'b1;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [1:0]  md;
        logic [1:0]  six;
    } exp_t;

    typedef struct {
        int          t1;
        logic [11:0] p1;
        int          t2;
        logic [11:0] p2;
        exp_t        e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];

    db9_md_pad_scanner #(
        .STEP_CYCLES   (STEP),
        .SETTLE_CYCLES (SETTLE),
        .GAP_CYCLES    (GAPC),
        .CNT_W         (17)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .joy_in     (joy_in),
        .joy_split  (joy_split),
        .joy_mdsel  (joy_mdsel),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .md_pad     (md_pad),
        .six_btn    (six_btn),
        .frame_done (frame_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Count SELECT falling edges per port, like the pad's own counter.
    always @(posedge clk_sys) begin
        if (!reset_n || joy_split != split_prev) begin
            nfall <= 0;
        end else if (mdsel_prev && !joy_mdsel) begin
            nfall <= nfall + 1;
        end
        split_prev <= joy_split;
        mdsel_prev <= joy_mdsel;
    end

    // p uses the output word layout; result is active-low lines.
    function automatic logic [5:0] pad_lines(int t, logic [11:0] p,
                                             logic sel, int n);
        logic [5:0] h;
        h = '0;
        if (t == PAD_ATARI) begin
            h = {p[5], p[4], p[0], p[1], p[2], p[3]};
        end else if (t == PAD_MD3 || t == PAD_MD6) begin
            if (sel) begin
                if (t == PAD_MD6 && n == 3)
                    h = {p[5], p[4], p[8], p[9], p[10], p[11]};
                else
                    h = {p[5], p[4], p[0], p[1], p[2], p[3]};
            end else begin
                if (t == PAD_MD6 && n == 3)
                    h = {p[7], p[6], 4'b1111};
                else if (t == PAD_MD6 && n == 4)
                    h = {p[7], p[6], 4'b0000};
                else
                    h = {p[7], p[6], 2'b11, p[2], p[3]};
            end
        end
        return ~h;
    endfunction

    always_comb begin
        joy_in = '1;
        if (joy_split)
            joy_in = pad_lines(type2, prs2, joy_mdsel, nfall);
        else
            joy_in = pad_lines(type1, prs1, joy_mdsel, nfall);
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_to(string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_j1"}, joystick1, 16'h0000);
        chk({tag, "_j2"}, joystick2, 16'h0000);
        chk({tag, "_md"}, {14'b0, md_pad}, 16'h0000);
        chk({tag, "_six"}, {14'b0, six_btn}, 16'h0000);
        chk({tag, "_split"}, {15'b0, joy_split}, 16'h0000);
        chk({tag, "_mdsel"}, {15'b0, joy_mdsel}, 16'h0001);
        chk({tag, "_fdone"}, {15'b0, frame_done}, 16'h0000);
    endtask

    // Expects reset_n low on entry; releases it and checks the idle run.
    task automatic reset_idle(string tag);
        repeat (3) @(negedge clk_sys);
        chk_reset_vals({tag, "_rst"});
        reset_n = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            @(posedge clk_sys);
            #1;
            if (i < 26) begin
                chk($sformatf("%s_mdsel_hi%0d", tag, i),
                    {15'b0, joy_mdsel}, 16'h0001);
                if (i == 20) begin
                    chk({tag, "_idle_split"}, {15'b0, joy_split}, 16'h0);
                    chk({tag, "_idle_j1"}, joystick1, 16'h0);
                    chk({tag, "_idle_j2"}, joystick2, 16'h0);
                end
            end else begin
                chk({tag, "_mdsel_fall26"}, {15'b0, joy_mdsel}, 16'h0);
            end
        end
    endtask

    // Waits for frame_done; pops and compares the scoreboard entry.
    task automatic wait_fd(string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk_sys);
        while (frame_done !== 1'b1 && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        if (frame_done !== 1'b1) begin
            fail_to({tag, "_frame_done"});
            return;
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_j1"}, joystick1, e.j1);
            chk({tag, "_j2"}, joystick2, e.j2);
            chk({tag, "_md"}, {14'b0, md_pad}, {14'b0, e.md});
            chk({tag, "_six"}, {14'b0, six_btn}, {14'b0, e.six});
        end
        @(negedge clk_sys);
        chk({tag, "_fdone_pulse"}, {15'b0, frame_done}, 16'h0);
    endtask

    task automatic wait_falls(int k, string tag);
        int   seen;
        int   n;
        logic prev;
        seen = 0;
        n    = 0;
        prev = joy_mdsel;
        while (seen < k && n < 300) begin
            @(negedge clk_sys);
            n++;
            if (prev && !joy_mdsel) seen++;
            prev = joy_mdsel;
        end
        if (seen < k) fail_to({tag, "_falls"});
    endtask

    task automatic wait_split(logic v, string tag);
        int n;
        n = 0;
        while (joy_split !== v && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        if (joy_split !== v) fail_to({tag, "_split"});
    endtask

    task automatic push(logic [15:0] j1, logic [15:0] j2,
                        logic [1:0] md, logic [1:0] six);
        exp_t e;
        e.j1  = j1;
        e.j2  = j2;
        e.md  = md;
        e.six = six;
        sbq.push_back(e);
    endtask

    initial begin
        vecs[0] = '{PAD_MD3,   12'h048, PAD_NONE,  12'h000,
                    '{16'h0048, 16'h0000, 2'b01, 2'b00}};
        vecs[1] = '{PAD_NONE,  12'h000, PAD_MD6,   12'h901,
                    '{16'h0000, 16'h0901, 2'b10, 2'b10}};
        vecs[2] = '{PAD_ATARI, 12'h012, PAD_NONE,  12'h000,
                    '{16'h0012, 16'h0000, 2'b00, 2'b00}};
        vecs[3] = '{PAD_ATARI, 12'h032, PAD_MD3,   12'h2B0,
                    '{16'h0032, 16'h00B0, 2'b10, 2'b00}};
        vecs[4] = '{PAD_MD6,   12'hFFF, PAD_MD6,   12'h000,
                    '{16'h0FFF, 16'h0000, 2'b11, 2'b11}};
        vecs[5] = '{PAD_NONE,  12'h000, PAD_NONE,  12'h000,
                    '{16'h0000, 16'h0000, 2'b00, 2'b00}};
        vecs[6] = '{PAD_MD3,   12'h3C5, PAD_ATARI, 12'h025,
                    '{16'h00C5, 16'h0025, 2'b01, 2'b00}};

        reset_idle("por");

        wait_fd("sync");
        for (int i = 0; i < 7; i++) begin
            type1 = vecs[i].t1;
            prs1  = vecs[i].p1;
            type2 = vecs[i].t2;
            prs2  = vecs[i].p2;
            sbq.push_back(vecs[i].e);
            wait_fd($sformatf("vec%0d", i));
        end

        // Buttons change during port 1 index 3.
        type1 = PAD_MD6;
        prs1  = 12'h001;
        type2 = PAD_NONE;
        prs2  = '0;
        push(16'h0001, 16'h0000, 2'b01, 2'b01);
        wait_fd("hold_pre");
        wait_falls(2, "hold_idx3");
        prs1 = 12'h901;
        chk("hold_idx3_j1", joystick1, 16'h0001);
        wait_falls(2, "hold_idx7");
        chk("hold_idx7_j1", joystick1, 16'h0001);
        wait_split(1'b1, "hold_commit");
        chk("hold_commit_j1", joystick1, 16'h0901);
        push(16'h0901, 16'h0000, 2'b01, 2'b01);
        wait_fd("hold_post");

        // Reset during port 2 index 4.
        wait_split(1'b1, "mrst");
        wait_falls(2, "mrst_idx3");
        begin
            int n;
            n = 0;
            while (joy_mdsel !== 1'b1 && n < 50) begin
                @(negedge clk_sys);
                n++;
            end
            if (joy_mdsel !== 1'b1) fail_to("mrst_idx4");
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mrst_async");
        reset_idle("mrst");
        push(16'h0901, 16'h0000, 2'b01, 2'b01);
        wait_fd("after_rst");

        chk("sb_empty", 16'(sbq.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
